// File: rtl/led_shift_pkg.sv
// Shared types and constants for the LED-shift sequencing controller.
package led_shift_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEFT    = 2'd1,
    RIGHT   = 2'd2,
    BLOCKED = 2'd3
  } shift_state_e;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 4;

  // The requested motion depends only on the synchronized button levels.
  // A conflict never prefers one side.
  function automatic shift_state_e next_state(input logic l, input logic r);
    shift_state_e s;
    s = IDLE;
    case ({l, r})
      2'b10:   s = LEFT;
      2'b01:   s = RIGHT;
      2'b11:   s = BLOCKED;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous button levels.
// A reset clears every stage to 0.
module btn_sync #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments, so every stage samples the pre-edge value of the stage before it.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_sync <= '0;
    else         r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/led_shift_ctrl.sv
// Button-driven one-hot LED stepper for the DE10-Lite demo.
// It gates the external tick counter and keeps a BCD count of the steps it executes.
module led_shift_ctrl
  import led_shift_pkg::*;
#(
  parameter int NUM_LEDS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          btn_left_ni,
  input  logic                          btn_right_ni,
  input  logic                          cnt_overflow_i,
  output logic                          cnt_enable_o,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic [$clog2(NUM_LEDS)-1:0]   pos_o,
  output logic                          dir_o,
  output logic                          moving_o,
  output logic [NUM_DIGITS*BCD_W-1:0]   steps_bcd_o
);

  localparam int                POS_W   = $clog2(NUM_LEDS);
  localparam int                STEPS_W = NUM_DIGITS * BCD_W;
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(NUM_LEDS - 1);

  function automatic logic [STEPS_W-1:0] bcd_inc(input logic [STEPS_W-1:0] v);
    logic [STEPS_W-1:0] res;
    logic               carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          res[i*BCD_W +: BCD_W] = '0;
        end else begin
          res[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry                 = 1'b0;
        end
      end
    end
    return res;
  endfunction

  logic [1:0]         w_lr;
  shift_state_e       w_next;
  shift_state_e       r_state;
  logic               r_moving;
  logic [POS_W-1:0]   r_pos;
  logic [NUM_LEDS-1:0] r_led;
  logic               r_dir;
  logic [STEPS_W-1:0] r_steps;

  btn_sync #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (~{btn_left_ni, btn_right_ni}),
    .q_o     (w_lr)
  );

  assign w_next = next_state(w_lr[1], w_lr[0]);

  // The enable is registered together with the state, so it cannot glitch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_moving <= (w_next == LEFT) || (w_next == RIGHT);
    end
  end

  // A step acts on the state held before this edge, even when that state is being left.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pos   <= '0;
      r_led   <= NUM_LEDS'(1);
      r_dir   <= 1'b0;
      r_steps <= '0;
    end else if (cnt_overflow_i) begin
      case (r_state)
        LEFT: begin
          r_pos   <= (r_pos == POS_MAX) ? '0 : r_pos + POS_W'(1);
          r_led   <= {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
          r_dir   <= 1'b1;
          r_steps <= bcd_inc(r_steps);
        end
        RIGHT: begin
          r_pos   <= (r_pos == '0) ? POS_MAX : r_pos - POS_W'(1);
          r_led   <= {r_led[0], r_led[NUM_LEDS-1:1]};
          r_dir   <= 1'b0;
          r_steps <= bcd_inc(r_steps);
        end
        default: ;
      endcase
    end
  end

  assign cnt_enable_o = r_moving;
  assign moving_o     = r_moving;
  assign pos_o        = r_pos;
  assign led_o        = r_led;
  assign dir_o        = r_dir;
  assign steps_bcd_o  = r_steps;

endmodule

// File: doc/led_shift_ctrl.md
# led_shift_ctrl

Sequencing controller for the LED-shift / 7-segment demo on the DE10-Lite. It synchronizes the two push-buttons and decides the shift direction, with simultaneous presses resolved to "no motion". It drives the enable of the external tick counter and consumes that counter's overflow pulse to step a one-hot LED position left or right. It also keeps a 6-digit BCD count of executed steps for the 7-segment display path.

## Interface
Parameters:
- NUM_LEDS, default 10: number of LEDs in the one-hot ring (≥2).
- SYNC_STAGES, default 2: flip-flop stages in each button synchronizer (≥2).

Ports:
- clk_i, input, 1: single system clock.
- reset_i, input, 1: reset, synchronous and active-high.
- btn_left_ni, input, 1: raw KEY, active-low; request shift left.
- btn_right_ni, input, 1: raw KEY, active-low; request shift right.
- cnt_overflow_i, input, 1: one-cycle step pulse from the tick counter.
- cnt_enable_o, output, 1: enable to the tick counter; the counter clears whenever this is low.
- led_o, output, NUM_LEDS: one-hot LED pattern, bit pos_o set.
- pos_o, output, $clog2(NUM_LEDS): current LED index.
- dir_o, output, 1: last commanded direction, 1 = left, 0 = right.
- moving_o, output, 1: high in LEFT or RIGHT.
- steps_bcd_o, output, 24: six BCD digits of the step count, digit 0 in [3:0].

## Operation
- Buttons are inverted, then passed through SYNC_STAGES flops to give L and R (active-high). No debounce is applied; the tick period masks bounce.
- FSM states: IDLE, LEFT, RIGHT, BLOCKED. The next state is a pure function of the synchronized L and R:
  - L & !R → LEFT
  - R & !L → RIGHT
  - L & R → BLOCKED
  - !L & !R → IDLE
- This mapping applies from every state. There are no priorities; a conflict always yields BLOCKED.
- cnt_enable_o = (state == LEFT) | (state == RIGHT). It is decoded from the state register and is glitch-free.
  - A direction change LEFT→RIGHT passes directly from one state to the other. The enable stays high, so the counter is not restarted.
- Step rule: on a cycle with cnt_overflow_i = 1, act on the current state register value, even if the state changes on that same edge.
  - LEFT: pos ← (pos == NUM_LEDS-1) ? 0 : pos+1; dir_o ← 1.
  - RIGHT: pos ← (pos == 0) ? NUM_LEDS-1 : pos-1; dir_o ← 0.
  - IDLE or BLOCKED: the overflow is ignored; pos and steps are unchanged.
- led_o is registered and is updated on the same edge as pos_o; it is never zero and never multi-hot.
- steps_bcd_o increments by 1 on every executed step.
  - Per-digit carry from 9 → 0.
  - Wraps 999999 → 000000.
  - No illegal BCD digit ever appears.
- Reset (any cycle, including mid-shift) sets:
  - state = IDLE
  - synchronizer flops = 0 (released)
  - pos_o = 0, led_o = 1
  - dir_o = 0, moving_o = 0, cnt_enable_o = 0
  - steps_bcd_o = 0
- reset_i has priority over cnt_overflow_i.

## Timing
- Button press → state change (and cnt_enable_o rise): SYNC_STAGES+1 clock edges.
- Button release → cnt_enable_o fall: SYNC_STAGES+1 edges.
- cnt_overflow_i → led_o, pos_o and steps_bcd_o update: 1 edge, all coherent in the same cycle.
- moving_o and cnt_enable_o are identical by construction.
- Back-to-back overflow pulses on consecutive cycles are each honoured; no minimum spacing is required.

## Structure
- Package led_shift_pkg holds:
  - shift_state_e enum {IDLE, LEFT, RIGHT, BLOCKED}
  - NUM_DIGITS = 6
  - BCD_W = 4
- Sub-module btn_sync (WIDTH, STAGES): a multi-bit synchronizer with synchronous active-high reset to 0, instantiated once for both buttons.
- The BCD incrementer is an internal function/always block; it is not a separate module.

## Test plan
- Reset state: hold reset_i 3 cycles, buttons released. Required: led_o = 10'b0000000001, pos_o = 0, steps_bcd_o = 0, cnt_enable_o = 0.
- Shift left with wrap: press left and inject 10 overflow pulses, 5 cycles apart.
  - pos_o sequence: 1, 2, …, 9, 0.
  - After the 9th pulse led_o = 10'b1000000000; after the 10th, 10'b0000000001.
  - steps_bcd_o = 24'h000010; dir_o = 1.
- Shift right from reset: press right, one pulse. Required: pos_o = 9, led_o = 10'b1000000000, dir_o = 0.
- Both buttons: press both, then inject 4 pulses.
  - state = BLOCKED and cnt_enable_o = 0 throughout.
  - pos_o and steps_bcd_o are unchanged.
  - Release right: after SYNC_STAGES+1 edges the state is LEFT.
- Overflow on exit edge: release the button so the state leaves LEFT on the same edge an overflow arrives. Required: the step is taken (pos +1), then cnt_enable_o = 0.
- BCD wrap and mid-run reset:
  - Preload steps via 999999 pulses (or a force), then one more pulse → steps_bcd_o = 24'h000000.
  - Assert reset_i mid-LEFT → all outputs return to reset values on the next edge.
